// File: rtl/vga_pkg.sv
// Shared VGA geometry and pixel-path constants.
// Used by the sprite mixer and its address generators.
package vga_pkg;
  localparam int H_VIS       = 640;
  localparam int V_VIS       = 480;
  localparam int RGB_W       = 12;
  localparam int COORD_W     = 10;
  localparam int ROM_LAT_MIN = 1;
  localparam int ROM_LAT_MAX = 3;
  localparam int SIZE_W      = 7;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [RGB_W-1:0]   rgb_t;
endpackage

// File: rtl/sprite_addr_gen.sv
// Window test and image-ROM address for one sprite channel.
// Purely combinational; the mixer registers the results.
module sprite_addr_gen
  import vga_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic [COORD_W-1:0] hc,
  input  logic [COORD_W-1:0] vc,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [SIZE_W-1:0]  w,
  input  logic [SIZE_W-1:0]  h,
  output logic               in_win,
  output logic [ADDR_W-1:0]  addr
);

  logic [COORD_W:0] xe;
  logic [COORD_W:0] ye;
  logic [COORD_W:0] dx;
  logic [COORD_W:0] dy;
  logic [17:0]      lin;

  // 11-bit ends so a sprite near the right/bottom edge never wraps
  assign xe = {1'b0, x} + {4'b0, w};
  assign ye = {1'b0, y} + {4'b0, h};

  assign in_win = (hc >= x) && ({1'b0, hc} < xe) &&
                  (vc >= y) && ({1'b0, vc} < ye);

  assign dx  = {1'b0, hc} - {1'b0, x};
  assign dy  = {1'b0, vc} - {1'b0, y};
  assign lin = {7'b0, dx} + {7'b0, dy} * {11'b0, w};

  assign addr = in_win ? ADDR_W'(lin) : '0;

endmodule

// File: rtl/vga_sprite_mixer.sv
// N-channel sprite compositor: ROM addressing, latency alignment,
// colour key, fixed priority and per-frame collision reporting.
module vga_sprite_mixer
  import vga_pkg::*;
#(
  parameter int               NSPR     = 4,
  parameter int               ROM_LAT  = 1,
  parameter logic [RGB_W-1:0] KEY      = 12'h000,
  parameter int               ADDR_W   = 17,
  parameter int               BG_SHIFT = 1,
  parameter int               BG_COLS  = 320
) (
  input  logic                     clk_25m,
  input  logic                     rst,
  input  logic                     valid,
  input  logic [COORD_W-1:0]       hc,
  input  logic [COORD_W-1:0]       vc,
  input  logic [NSPR-1:0]          spr_en,
  input  logic [NSPR*COORD_W-1:0]  spr_x,
  input  logic [NSPR*COORD_W-1:0]  spr_y,
  input  logic [NSPR*SIZE_W-1:0]   spr_w,
  input  logic [NSPR*SIZE_W-1:0]   spr_h,
  output logic [NSPR*ADDR_W-1:0]   spr_addr,
  input  logic [NSPR*RGB_W-1:0]    spr_data,
  output logic [ADDR_W-1:0]        bg_addr,
  input  logic [RGB_W-1:0]         bg_data,
  output logic [3:0]               vgaRed,
  output logic [3:0]               vgaGreen,
  output logic [3:0]               vgaBlue,
  output logic [NSPR-1:0]          hit,
  output logic [NSPR-1:0]          coll_flags,
  output logic                     frame_done
);

  logic [NSPR-1:0]        in_c;
  logic [NSPR*ADDR_W-1:0] addr_c;
  logic [ADDR_W-1:0]      bg_c;
  logic [COORD_W-1:0]     bh;
  logic [COORD_W-1:0]     bv;
  logic                   first_c;

  for (genvar i = 0; i < NSPR; i++) begin : g_ch
    sprite_addr_gen #(.ADDR_W(ADDR_W)) u_gen (
      .hc     (hc),
      .vc     (vc),
      .x      (spr_x[i*COORD_W +: COORD_W]),
      .y      (spr_y[i*COORD_W +: COORD_W]),
      .w      (spr_w[i*SIZE_W +: SIZE_W]),
      .h      (spr_h[i*SIZE_W +: SIZE_W]),
      .in_win (in_c[i]),
      .addr   (addr_c[i*ADDR_W +: ADDR_W])
    );
  end

  assign bh      = hc >> BG_SHIFT;
  assign bv      = vc >> BG_SHIFT;
  assign bg_c    = ADDR_W'(bh) + ADDR_W'(BG_COLS) * ADDR_W'(bv);
  assign first_c = (hc == '0) && (vc == '0);

  // Index 0 is stage A; index ROM_LAT lines up with ROM data
  logic [ROM_LAT:0][NSPR-1:0] in_p;
  logic [ROM_LAT:0][NSPR-1:0] en_p;
  logic [ROM_LAT:0]           valid_p;
  logic [ROM_LAT:0]           first_p;

  always_ff @(posedge clk_25m) begin
    if (rst) begin
      spr_addr <= '0;
      bg_addr  <= '0;
      in_p     <= '0;
      en_p     <= '0;
      valid_p  <= '0;
      first_p  <= '0;
    end else begin
      spr_addr <= addr_c;
      bg_addr  <= bg_c;
      in_p     <= {in_p[ROM_LAT-1:0], in_c};
      en_p     <= {en_p[ROM_LAT-1:0], spr_en};
      valid_p  <= {valid_p[ROM_LAT-1:0], valid};
      first_p  <= {first_p[ROM_LAT-1:0], first_c};
    end
  end

  logic [NSPR-1:0]  opaque;
  logic [NSPR-1:0]  om1;
  logic [NSPR-1:0]  contrib;
  logic [RGB_W-1:0] pix;
  logic             multi;
  logic             valid_b;
  logic             first_b;

  assign valid_b = valid_p[ROM_LAT];
  assign first_b = first_p[ROM_LAT];

  always_comb begin
    opaque = '0;
    pix    = bg_data;
    for (int i = NSPR - 1; i >= 0; i--) begin
      opaque[i] = in_p[ROM_LAT][i] && en_p[ROM_LAT][i] &&
                  (spr_data[i*RGB_W +: RGB_W] != KEY);
      if (opaque[i]) pix = spr_data[i*RGB_W +: RGB_W];
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set
  assign om1     = opaque - NSPR'(1);
  assign multi   = (opaque & om1) != '0;
  assign contrib = (valid_b && multi) ? opaque : '0;

  logic [RGB_W-1:0] rgb;
  logic [NSPR-1:0]  coll_acc;

  always_ff @(posedge clk_25m) begin
    if (rst) begin
      rgb        <= '0;
      hit        <= '0;
      coll_flags <= '0;
      frame_done <= 1'b0;
      coll_acc   <= '0;
    end else begin
      rgb        <= valid_b ? pix : '0;
      hit        <= valid_b ? opaque : '0;
      frame_done <= first_b;
      if (first_b) begin
        coll_flags <= coll_acc;
        coll_acc   <= contrib;
      end else begin
        coll_acc   <= coll_acc | contrib;
      end
    end
  end

  assign vgaRed   = rgb[11:8];
  assign vgaGreen = rgb[7:4];
  assign vgaBlue  = rgb[3:0];

endmodule

// File: tb/tb_vga_sprite_mixer.sv
// Directed bench for vga_sprite_mixer at ROM_LAT=1 and ROM_LAT=3.
// Both instances see one stimulus stream; each is checked at its own latency.
module tb_vga_sprite_mixer;

  localparam int N  = 4;
  localparam int AW = 17;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic            rst;
  logic            valid;
  logic [9:0]      hc;
  logic [9:0]      vc;
  logic [N-1:0]    spr_en;
  logic [N*10-1:0] spr_x;
  logic [N*10-1:0] spr_y;
  logic [N*7-1:0]  spr_w;
  logic [N*7-1:0]  spr_h;
  logic [11:0]     colour [N];
  logic [N*12-1:0] col_bus;

  assign col_bus = {colour[3], colour[2], colour[1], colour[0]};

  logic [N*AW-1:0] a1, a3;
  logic [AW-1:0]   b1, b3;
  logic [3:0]      r1, g1, bl1, r3, g3, bl3;
  logic [N-1:0]    hit1, hit3, cf1, cf3;
  logic            fd1, fd3;
  logic [N*12-1:0] d1, d3, d3a, d3b;
  logic [11:0]     bgd1, bgd3, bg3a, bg3b;

  // Behavioural image ROMs: sprite ROMs return the channel colour,
  // the background ROM returns the low 12 address bits.
  always @(posedge clk) begin
    d1   <= col_bus;
    bgd1 <= b1[11:0];
    d3a  <= col_bus;
    d3b  <= d3a;
    d3   <= d3b;
    bg3a <= b3[11:0];
    bg3b <= bg3a;
    bgd3 <= bg3b;
  end

  vga_sprite_mixer #(.NSPR(N), .ROM_LAT(1)) u1 (
    .clk_25m(clk), .rst(rst), .valid(valid), .hc(hc), .vc(vc),
    .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y),
    .spr_w(spr_w), .spr_h(spr_h), .spr_addr(a1), .spr_data(d1),
    .bg_addr(b1), .bg_data(bgd1), .vgaRed(r1), .vgaGreen(g1),
    .vgaBlue(bl1), .hit(hit1), .coll_flags(cf1), .frame_done(fd1)
  );

  vga_sprite_mixer #(.NSPR(N), .ROM_LAT(3)) u3 (
    .clk_25m(clk), .rst(rst), .valid(valid), .hc(hc), .vc(vc),
    .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y),
    .spr_w(spr_w), .spr_h(spr_h), .spr_addr(a3), .spr_data(d3),
    .bg_addr(b3), .bg_data(bgd3), .vgaRed(r3), .vgaGreen(g3),
    .vgaBlue(bl3), .hit(hit3), .coll_flags(cf3), .frame_done(fd3)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hc    = 10'd600;
    vc    = 10'd400;
    valid = 1'b1;
  endtask

  task automatic set_spr(input int i, input logic [9:0] x, y,
                         input logic [6:0] w, h, input logic en,
                         input logic [11:0] c);
    spr_x[i*10 +: 10] = x;
    spr_y[i*10 +: 10] = y;
    spr_w[i*7 +: 7]   = w;
    spr_h[i*7 +: 7]   = h;
    spr_en[i]         = en;
    colour[i]         = c;
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_rgb1"}, {r1, g1, bl1}, 0);
    chk({tag, "_rgb3"}, {r3, g3, bl3}, 0);
    chk({tag, "_hit1"}, hit1, 0);
    chk({tag, "_hit3"}, hit3, 0);
    chk({tag, "_cf1"}, cf1, 0);
    chk({tag, "_cf3"}, cf3, 0);
    chk({tag, "_fd1"}, fd1, 0);
    chk({tag, "_fd3"}, fd3, 0);
    chk({tag, "_addr1"}, a1, 0);
    chk({tag, "_bg1"}, b1, 0);
    chk({tag, "_addr3"}, a3, 0);
  endtask

  // One pixel at (h,v) followed by idle pixels; dut1 shows it
  // 3 edges after sampling, dut3 5 edges after.
  task automatic show(input string tag, input logic [9:0] h, v,
                      input logic vl, input logic [16:0] ea0, ea1,
                      input logic [11:0] ergb, input logic [3:0] ehit,
                      input logic efd);
    logic [16:0] eb;
    eb    = 17'(h >> 1) + 17'd320 * 17'(v >> 1);
    hc    = h;
    vc    = v;
    valid = vl;
    tick();
    chk({tag, "_a0"}, a1[16:0], ea0);
    chk({tag, "_a1"}, a1[33:17], ea1);
    chk({tag, "_bga"}, b1, eb);
    idle();
    tick();
    tick();
    chk({tag, "_rgb1"}, {r1, g1, bl1}, ergb);
    chk({tag, "_hit1"}, hit1, ehit);
    chk({tag, "_fd1"}, fd1, efd);
    tick();
    chk({tag, "_fd1_off"}, fd1, 0);
    tick();
    chk({tag, "_rgb3"}, {r3, g3, bl3}, ergb);
    chk({tag, "_hit3"}, hit3, ehit);
    chk({tag, "_fd3"}, fd3, efd);
  endtask

  task automatic coll_chk(input string tag, input logic [3:0] e);
    chk({tag, "_cf1"}, cf1, e);
    chk({tag, "_cf3"}, cf3, e);
  endtask

  initial begin
    rst    = 1'b1;
    spr_en = '0;
    spr_x  = '0;
    spr_y  = '0;
    spr_w  = '0;
    spr_h  = '0;
    idle();
    set_spr(0, 10'd100, 10'd50, 7'd30, 7'd50, 1'b1, 12'hF00);
    set_spr(1, 10'd200, 10'd200, 7'd20, 7'd20, 1'b0, 12'h00F);
    set_spr(2, 10'd0, 10'd0, 7'd0, 7'd5, 1'b1, 12'hFFF);
    set_spr(3, 10'd0, 10'd0, 7'd5, 7'd0, 1'b1, 12'hFFF);
    repeat (4) tick();
    zero_chk("reset");
    rst = 1'b0;

    show("tl", 10'd100, 10'd50, 1, 0, 0, 12'hF00, 4'b0001, 0);
    show("br", 10'd129, 10'd99, 1, 1499, 0, 12'hF00, 4'b0001, 0);
    show("out", 10'd130, 10'd99, 1, 0, 0, 12'hD81, 4'b0000, 0);
    show("dis", 10'd205, 10'd205, 1, 0, 105, 12'hFE6, 4'b0000, 0);

    set_spr(0, 10'd3, 10'd50, 7'd30, 7'd50, 1'b1, 12'hF00);
    show("wrap", 10'd0, 10'd50, 1, 0, 0, 12'hF40, 4'b0000, 0);
    show("lft", 10'd3, 10'd50, 1, 0, 0, 12'hF00, 4'b0001, 0);
    show("rgt", 10'd32, 10'd60, 1, 329, 0, 12'hF00, 4'b0001, 0);
    show("rgt1", 10'd33, 10'd60, 1, 0, 0, 12'h590, 4'b0000, 0);

    set_spr(0, 10'd190, 10'd190, 7'd30, 7'd30, 1'b1, 12'h0F0);
    spr_en[1] = 1'b1;
    show("ovl", 10'd200, 10'd200, 1, 310, 0, 12'h0F0, 4'b0011, 0);
    show("fr1", 10'd0, 10'd0, 1, 0, 0, 12'h000, 4'b0000, 1);
    coll_chk("fr1", 4'b0011);

    colour[0] = 12'h000;
    show("key", 10'd205, 10'd205, 1, 465, 105, 12'h00F, 4'b0010, 0);
    show("fr2", 10'd0, 10'd0, 1, 0, 0, 12'h000, 4'b0000, 1);
    coll_chk("fr2", 4'b0000);

    colour[0] = 12'h0F0;
    show("ovl2", 10'd200, 10'd200, 1, 310, 0, 12'h0F0, 4'b0011, 0);
    show("fr3", 10'd0, 10'd0, 1, 0, 0, 12'h000, 4'b0000, 1);
    coll_chk("fr3", 4'b0011);
    show("pend", 10'd200, 10'd200, 1, 310, 0, 12'h0F0, 4'b0011, 0);
    hc  = 10'd200;
    vc  = 10'd200;
    rst = 1'b1;
    tick();
    zero_chk("mrst");
    rst = 1'b0;
    idle();
    show("fr4", 10'd0, 10'd0, 1, 0, 0, 12'h000, 4'b0000, 1);
    coll_chk("fr4", 4'b0000);

    show("inv", 10'd200, 10'd200, 0, 310, 0, 12'h000, 4'b0000, 0);
    show("fr5", 10'd0, 10'd0, 1, 0, 0, 12'h000, 4'b0000, 1);
    coll_chk("fr5", 4'b0000);

    show("ovl3", 10'd210, 10'd210, 1, 620, 210, 12'h0F0, 4'b0011, 0);
    show("fr6", 10'd0, 10'd0, 1, 0, 0, 12'h000, 4'b0000, 1);
    coll_chk("fr6", 4'b0011);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sprite_mixer.md
Name: vga_sprite_mixer

Overview:
- Parametrised N-channel sprite compositor for the 640x480 VGA path. Replaces the fixed per-sprite blend logic with generic channels.
- Generates background and per-sprite image-ROM addresses from the monitor coordinate (hc, vc).
- Compensates for ROM read latency, applies a colour key and fixed priority, and outputs registered 12-bit RGB.
- Also reports per-frame opaque-pixel sprite collisions to game logic, e.g. bullet hits boss.

Parameters:
- NSPR, 4: number of sprite channels; channel 0 has the highest priority.
- ROM_LAT, 1: read latency of every image ROM in cycles, 1..3.
- KEY, 12'h000: transparent colour key.
- ADDR_W, 17: ROM address width.
- BG_SHIFT, 1: background downscale shift (1 gives a 320x240 image).
- BG_COLS, 320: background image row length in pixels.

Ports:
- clk_25m  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- valid  in  1  visible-area flag, aligned with hc/vc
- hc  in  10  current pixel column
- vc  in  10  current pixel row
- spr_en  in  NSPR  per-sprite existence
- spr_x  in  NSPR*10  top-left column per sprite, channel i at [10i+9:10i]
- spr_y  in  NSPR*10  top-left row per sprite
- spr_w  in  NSPR*7  sprite width in pixels, 1..127
- spr_h  in  NSPR*7  sprite height in pixels, 1..127
- spr_addr  out  NSPR*ADDR_W  ROM address per sprite
- spr_data  in  NSPR*12  ROM data per sprite, valid ROM_LAT cycles after spr_addr
- bg_addr  out  ADDR_W  background ROM address
- bg_data  in  12  background ROM data
- vgaRed  out  4  red output
- vgaGreen  out  4  green output
- vgaBlue  out  4  blue output
- hit  out  NSPR  opaque-sprite mask of the pixel currently shown on RGB
- coll_flags  out  NSPR  sprites that overlapped another opaque sprite in the last completed frame
- frame_done  out  1  one-cycle pulse when coll_flags updates

Behaviour:
- Reset (synchronous, rst=1 at a clk_25m edge) clears:
  - RGB, hit, coll_flags, frame_done, the accumulator and all pipeline flags, all to 0;
  - spr_addr and bg_addr, to 0.
- Stage A (cycle t): register the addresses and window flags for the sampled hc/vc.
  - Window test uses 11-bit unsigned arithmetic, so there is no wrap near the screen edge: in_i = hc>=x_i && hc<x_i+w_i && vc>=y_i && vc<y_i+h_i.
  - spr_addr_i = (hc-x_i) + w_i*(vc-y_i) when in_i, else 0.
  - bg_addr = (hc>>BG_SHIFT) + BG_COLS*(vc>>BG_SHIFT).
- in_i, spr_en_i, valid and a first-pixel flag (hc==0 && vc==0) travel through a shift pipeline ROM_LAT deep, aligned with the ROM data.
- Stage B (cycle t+1+ROM_LAT):
  - opaque_i = in_i && spr_en_i && spr_data_i != KEY.
  - Pixel = spr_data of the lowest-index opaque channel, else bg_data.
  - Result is registered to RGB and hit. Total latency hc/vc -> RGB is ROM_LAT+2 cycles.
- valid low in stage B: RGB=0, hit=0, no collision accumulation.
- Collision accumulation: when at least two bits of opaque are set, coll_acc |= opaque.
- Frame boundary, when stage B carries the first-pixel flag:
  - coll_flags <= coll_acc;
  - coll_acc <= contribution of this pixel only;
  - frame_done = 1 for exactly that cycle.
- The first frame_done after a reset reports only a partial frame. This is intentional.
- Sprite inputs may change at any time. They are sampled each cycle at stage A, with no shadowing.
- Zero-size sprites (w or h = 0) are never in-window.

Decomposition:
- Shared package vga_pkg holds H_VIS=640, V_VIS=480, RGB_W=12, COORD_W=10 and the ROM_LAT limits.
- One sub-module, sprite_addr_gen: window test and address calculation for one channel, instantiated NSPR times by generate.
- Priority mux and collision accumulator stay in the top module.

Test Plan:
- Sprite 0 at (100,50), 30x50, enabled, ROM returns 12'hF00; hc=100, vc=50 -> spr_addr0=0 and RGB=F,0,0 exactly ROM_LAT+2 cycles later. Repeat for hc=129, vc=99 -> spr_addr0=1499. At hc=130 the sprite is out-of-window and RGB shows background.
- Sprites 0 and 1 overlap at (200,200), both opaque with 12'h0F0 and 12'h00F -> output 12'h0F0 and hit=0011. At the next first-pixel pulse, coll_flags=0011 and frame_done lasts one cycle.
- Sprite 0 data equals KEY over an area that sprite 1 covers opaque -> sprite 1 colour shown, and no collision flag for the pair.
- Sprite at x=3, w=30, with hc=0 -> not in-window and no wraparound hit. With hc=3 -> addr=0.
- rst asserted mid-frame with a collision pending -> the next cycle has all outputs 0. The following frame_done reports only post-reset collisions.
- valid=0 with sprites on screen -> RGB=0 and hit=0. Frame sweep with ROM_LAT=1 and ROM_LAT=3 -> identical pixel stream, shifted by 2 cycles.
